// File: rtl/out_serializer_pkg.sv
// ---------------------------------------------------------------------------
// out_serializer_pkg
// Shared definitions for the output serializer: lane count, the bank
// occupancy state encoding, the 2-bit lane-count type and a helper that
// maps the "0 means all lanes" encoding to a literal count.
// ---------------------------------------------------------------------------
package out_serializer_pkg;

    localparam int N_LANES = 3;

    typedef logic [1:0] lane_cnt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    // A lane count of 0 stands for a full beat of N_LANES words.
    function automatic lane_cnt_t eff_lanes(input lane_cnt_t n);
        return (n == 2'd0) ? lane_cnt_t'(N_LANES) : n;
    endfunction

endpackage

// File: rtl/out_serializer_if.sv
// ---------------------------------------------------------------------------
// out_serializer_if
// Handshake bundle between a beat producer and the output serializer.
//   in_1..in_3  parallel lane data          n_lanes   lanes in this beat
//   in_valid    beat offered                in_ready  serializer can accept
//   out         serial word                 out_valid out holds a word
//   out_ready   downstream accepts out      out_last  last word of its beat
// out_last exists only when OUT_SER_LAST_EN is defined.
// Modports: slave = serializer side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface out_serializer_if #(
    parameter int IO_DATA_WIDTH = 16
);
    import out_serializer_pkg::*;

    logic [IO_DATA_WIDTH-1:0] in_1;
    logic [IO_DATA_WIDTH-1:0] in_2;
    logic [IO_DATA_WIDTH-1:0] in_3;
    lane_cnt_t                n_lanes;
    logic                     in_valid;
    logic                     in_ready;
    logic [IO_DATA_WIDTH-1:0] out;
    logic                     out_valid;
    logic                     out_ready;
`ifdef OUT_SER_LAST_EN
    logic                     out_last;
`endif

    modport slave (
        input  in_1, in_2, in_3, n_lanes, in_valid, out_ready,
        output in_ready, out, out_valid
`ifdef OUT_SER_LAST_EN
        , output out_last
`endif
    );

    modport master (
        output in_1, in_2, in_3, n_lanes, in_valid, out_ready,
        input  in_ready, out, out_valid
`ifdef OUT_SER_LAST_EN
        , input out_last
`endif
    );

endinterface

// File: rtl/out_serializer_lane_bank.sv
// ---------------------------------------------------------------------------
// lane_bank
// One ping-pong bank: N_LANES lane registers, the beat's lane count and a
// full flag. load captures a beat and sets full; clear drops full. The
// contents are only written on load, so a full bank is stable until freed.
//   clk, arst_in   clock, async active-high reset
//   load, clear    capture beat / release bank (load wins if both)
//   d_1..d_3, d_n  beat data and lane count to capture
//   sel            lane index to present on word
//   word, n_lanes, full   selected lane, stored count, occupancy flag
// ---------------------------------------------------------------------------
module lane_bank
    import out_serializer_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         arst_in,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d_1,
    input  logic [W-1:0] d_2,
    input  logic [W-1:0] d_3,
    input  lane_cnt_t    d_n,
    input  lane_cnt_t    sel,
    output logic [W-1:0] word,
    output lane_cnt_t    n_lanes,
    output logic         full
);

    logic [W-1:0] lane_q [N_LANES];

    // NOTE: the lane registers are reset as well as the flag, so out reads
    // 0 straight after reset instead of stale data from before it.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            for (int i = 0; i < N_LANES; i++) lane_q[i] <= '0;
            n_lanes <= '0;
            full    <= 1'b0;
        end else if (load) begin
            // NOTE: non-blocking assignments keep every register update
            // in this edge based on pre-edge values.
            lane_q[0] <= d_1;
            lane_q[1] <= d_2;
            lane_q[2] <= d_3;
            n_lanes   <= d_n;
            full      <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

    // NOTE: word is given a value on every path so no latch is inferred.
    always_comb begin
        word = lane_q[2];
        case (sel)
            2'd0:    word = lane_q[0];
            2'd1:    word = lane_q[1];
            default: word = lane_q[2];
        endcase
    end

endmodule

// File: rtl/out_serializer.sv
// ---------------------------------------------------------------------------
// out_serializer
// Turns parallel beats of up to three lanes into a stream of single words.
// Two ping-pong lane_bank instances buffer beats; an EMPTY/ONE/TWO FSM
// tracks how many are full. in_ready depends only on registered state.
//   clk       clock, rising edge
//   arst_in   async active-high reset, clears all state and banks
//   bus       out_serializer_if.slave (beat input, serial output)
// Optional feature: define OUT_SER_LAST_EN to drive bus.out_last.
// ---------------------------------------------------------------------------
module out_serializer
    import out_serializer_pkg::*;
#(
    parameter int IO_DATA_WIDTH = 16
) (
    input  logic           clk,
    input  logic           arst_in,
    out_serializer_if.slave bus
);

    occ_state_t state_q, state_d;
    logic       wr_ptr, rd_ptr;
    lane_cnt_t  idx;

    logic [IO_DATA_WIDTH-1:0] word_0, word_1;
    lane_cnt_t                n_0, n_1;
    logic                     full_0, full_1;

    logic [IO_DATA_WIDTH-1:0] cur_word;
    lane_cnt_t                cur_n;
    lane_cnt_t                last_idx;
    logic                     cur_full;
    logic                     accept, drain, free;

    assign bus.in_ready = (state_q != TWO);
    assign accept       = bus.in_valid && bus.in_ready;

    assign cur_word = rd_ptr ? word_1 : word_0;
    assign cur_n    = rd_ptr ? n_1    : n_0;
    assign cur_full = rd_ptr ? full_1 : full_0;
    assign last_idx = eff_lanes(cur_n) - 2'd1;

    assign bus.out       = cur_word;
    assign bus.out_valid = cur_full;
    assign drain         = cur_full && bus.out_ready;
    assign free          = drain && (idx == last_idx);

`ifdef OUT_SER_LAST_EN
    assign bus.out_last = cur_full && (idx == last_idx);
`endif

    lane_bank #(.W(IO_DATA_WIDTH)) u_bank_0 (
        .clk     (clk),
        .arst_in (arst_in),
        .load    (accept && !wr_ptr),
        .clear   (free && !rd_ptr),
        .d_1     (bus.in_1),
        .d_2     (bus.in_2),
        .d_3     (bus.in_3),
        .d_n     (bus.n_lanes),
        .sel     (idx),
        .word    (word_0),
        .n_lanes (n_0),
        .full    (full_0)
    );

    lane_bank #(.W(IO_DATA_WIDTH)) u_bank_1 (
        .clk     (clk),
        .arst_in (arst_in),
        .load    (accept && wr_ptr),
        .clear   (free && rd_ptr),
        .d_1     (bus.in_1),
        .d_2     (bus.in_2),
        .d_3     (bus.in_3),
        .d_n     (bus.n_lanes),
        .sel     (idx),
        .word    (word_1),
        .n_lanes (n_1),
        .full    (full_1)
    );

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q <= EMPTY;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            idx     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) wr_ptr <= !wr_ptr;
            if (free) begin
                rd_ptr <= !rd_ptr;
                idx    <= '0;
            end else if (drain) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Accept and free in the same cycle cancel out, keeping occupancy.
    always_comb begin
        state_d = state_q;
        case ({accept, free})
            2'b10: begin
                case (state_q)
                    EMPTY:   state_d = ONE;
                    ONE:     state_d = TWO;
                    default: state_d = state_q;
                endcase
            end
            2'b01: begin
                case (state_q)
                    TWO:     state_d = ONE;
                    ONE:     state_d = EMPTY;
                    default: state_d = state_q;
                endcase
            end
            default: state_d = state_q;
        endcase
    end

endmodule
